// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and default device address for the I2C register bridge
package i2c_pkg;

  localparam logic [6:0] DEFAULT_I2C_ADDRESS = 7'h42;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PTR      = 3'd1,
    WDATA    = 3'd2,
    WR_BUS   = 3'd3,
    RD_BUS   = 3'd4,
    RD_READY = 3'd5
  } state_t;

endpackage

// File: rtl/i2c_bus_timeout.sv
// rtl/i2c_bus_timeout.sv - cycle counter that flags when a register access has waited LIMIT cycles
module i2c_bus_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] count;

  // expired fires during the LIMIT-th enabled cycle, so the request is held exactly LIMIT cycles
  assign expired = enable && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_reg_bridge.sv
// rtl/i2c_reg_bridge.sv - I2C slave byte stream to register bus bridge with auto-incrementing pointer
module i2c_reg_bridge
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = DEFAULT_I2C_ADDRESS,
  parameter int         REG_ADDR_W  = 4,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i2c_addr_rw,
  input  logic                  i2c_addr_rw_valid_stb,
  input  logic [7:0]            i2c_data_rx,
  input  logic                  i2c_data_rx_valid_stb,
  input  logic                  i2c_data_tx_done_stb,
  input  logic                  i2c_error_stb,
  output logic [7:0]            i2c_data_tx,
  output logic                  stall,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  input  logic                  reg_ack,
  output logic                  timeout_err
);

  state_t                state, state_next;
  logic [REG_ADDR_W-1:0] ptr;
  logic                  addr_hit, busy, expired, tmo_load;
  logic                  ptr_load, ptr_inc, wr_launch, rd_launch;
  logic                  tx_from_bus, tx_timeout, set_timeout;

  assign addr_hit = i2c_addr_rw_valid_stb && (i2c_addr_rw[7:1] == I2C_ADDRESS);
  assign busy     = (state == WR_BUS) || (state == RD_BUS);
  assign reg_we   = (state == WR_BUS);
  assign reg_re   = (state == RD_BUS);
  assign tmo_load = !busy;
  // launching an access stretches the clock in the strobe cycle itself
  assign stall    = busy || ((wr_launch || rd_launch) && !rst);

  i2c_bus_timeout #(.LIMIT(ACK_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .enable  (busy),
    .expired (expired)
  );

  always_comb begin
    state_next  = state;
    ptr_load    = 1'b0;
    ptr_inc     = 1'b0;
    wr_launch   = 1'b0;
    rd_launch   = 1'b0;
    tx_from_bus = 1'b0;
    tx_timeout  = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE, PTR, WDATA, RD_READY: begin
        if (i2c_addr_rw_valid_stb) begin
          if (!addr_hit) begin
            state_next = IDLE;
          end else if (i2c_addr_rw[0]) begin
            rd_launch  = 1'b1;
            state_next = RD_BUS;
          end else begin
            state_next = PTR;
          end
        end else if (state == PTR && i2c_data_rx_valid_stb) begin
          ptr_load   = 1'b1;
          state_next = WDATA;
        end else if (state == WDATA && i2c_data_rx_valid_stb) begin
          wr_launch  = 1'b1;
          state_next = WR_BUS;
        end else if (state == RD_READY && i2c_data_tx_done_stb) begin
          rd_launch  = 1'b1;
          state_next = RD_BUS;
        end
      end
      WR_BUS: begin
        if (reg_ack) begin
          ptr_inc    = 1'b1;
          state_next = WDATA;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_next  = WDATA;
        end
      end
      RD_BUS: begin
        if (reg_ack) begin
          ptr_inc     = 1'b1;
          tx_from_bus = 1'b1;
          state_next  = RD_READY;
        end else if (expired) begin
          set_timeout = 1'b1;
          tx_timeout  = 1'b1;
          state_next  = RD_READY;
        end
      end
      default: state_next = IDLE;
    endcase
    // a bus error abandons everything, including an ack arriving in the same cycle
    if (i2c_error_stb) begin
      state_next  = IDLE;
      ptr_load    = 1'b0;
      ptr_inc     = 1'b0;
      wr_launch   = 1'b0;
      rd_launch   = 1'b0;
      tx_from_bus = 1'b0;
      tx_timeout  = 1'b0;
      set_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      reg_addr    <= '0;
      reg_wdata   <= 8'h00;
      i2c_data_tx <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      if (ptr_load) begin
        ptr <= i2c_data_rx[REG_ADDR_W-1:0];
      end else if (ptr_inc) begin
        ptr <= ptr + 1'b1;
      end
      if (wr_launch) begin
        reg_wdata <= i2c_data_rx;
      end
      if (wr_launch || rd_launch) begin
        reg_addr <= ptr;
      end
      if (tx_from_bus) begin
        i2c_data_tx <= reg_rdata;
      end else if (tx_timeout) begin
        i2c_data_tx <= 8'hFF;
      end
      if (set_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// tb/tb_i2c_reg_bridge.sv - randomized self-checking bench for i2c_reg_bridge against a session-level model
module tb_i2c_reg_bridge;

  localparam int         ACK_TO = 20;
  localparam logic [6:0] DEV    = 7'h42;
  localparam int         M_IDLE = 0, M_PTR = 1, M_WDATA = 2, M_RD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i2c_addr_rw, i2c_data_rx, i2c_data_tx, reg_wdata, reg_rdata;
  logic       addr_stb, rx_stb, tx_done, err_stb;
  logic       stall, reg_we, reg_re, reg_ack, timeout_err;
  logic [3:0] reg_addr;

  int         total = 0;
  int         bad = 0;
  logic [7:0] slave_mem [16];
  logic [7:0] ref_regs  [16];
  int         ref_ptr;
  int         mode;
  logic       exp_to;

  i2c_reg_bridge #(.I2C_ADDRESS(DEV), .REG_ADDR_W(4), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i2c_addr_rw           (i2c_addr_rw),
    .i2c_addr_rw_valid_stb (addr_stb),
    .i2c_data_rx           (i2c_data_rx),
    .i2c_data_rx_valid_stb (rx_stb),
    .i2c_data_tx_done_stb  (tx_done),
    .i2c_error_stb         (err_stb),
    .i2c_data_tx           (i2c_data_tx),
    .stall                 (stall),
    .reg_addr              (reg_addr),
    .reg_wdata             (reg_wdata),
    .reg_we                (reg_we),
    .reg_re                (reg_re),
    .reg_rdata             (reg_rdata),
    .reg_ack               (reg_ack),
    .timeout_err           (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Plays the register slave while a request is up; delay >= ACK_TO means the ack is withheld.
  task automatic service(input logic is_wr, input int delay, input logic [7:0] wbyte);
    int   hi;
    logic ok;
    hi = 0;
    check(is_wr ? "wr_addr" : "rd_addr", reg_addr, ref_ptr);
    if (is_wr) check("wr_data", reg_wdata, wbyte);
    for (int i = 0; i < ACK_TO + 4; i++) begin
      if (!(is_wr ? reg_we : reg_re)) break;
      hi++;
      check("we_re_excl", reg_we & reg_re, 0);
      check("bus_stall", stall, 1);
      if (i == delay) begin
        reg_ack = 1'b1;
        if (is_wr) slave_mem[reg_addr] = reg_wdata;
        else reg_rdata = slave_mem[reg_addr];
      end
      step();
      reg_ack   = 1'b0;
      reg_rdata = 8'($urandom);
      #1;
    end
    ok = (delay < ACK_TO);
    check("req_cycles", hi, ok ? delay + 1 : ACK_TO);
    check("stall_release", stall, 0);
    if (!ok) exp_to = 1'b1;
    if (is_wr && ok) ref_regs[ref_ptr] = wbyte;
    if (!is_wr) check("tx_data", i2c_data_tx, ok ? ref_regs[ref_ptr] : 8'hFF);
    if (ok) ref_ptr = (ref_ptr + 1) % 16;
    check("timeout_err", timeout_err, exp_to);
  endtask

  task automatic addr_phase(input logic [6:0] a7, input logic rw, input int delay);
    logic hit;
    hit = (a7 == DEV);
    step();
    i2c_addr_rw = {a7, rw};
    addr_stb    = 1'b1;
    #1;
    check("addr_stall", stall, hit && rw);
    step();
    addr_stb = 1'b0;
    #1;
    if (!hit) mode = M_IDLE;
    else if (rw) mode = M_RD;
    else mode = M_PTR;
    if (hit && rw) service(1'b0, delay, 8'h00);
    else check("addr_no_req", reg_we | reg_re | stall, 0);
  endtask

  task automatic rx_byte(input logic [7:0] b, input int delay);
    step();
    i2c_data_rx = b;
    rx_stb      = 1'b1;
    #1;
    check("rx_stall", stall, mode == M_WDATA);
    step();
    rx_stb = 1'b0;
    #1;
    if (mode == M_PTR) begin
      ref_ptr = b % 16;
      mode    = M_WDATA;
      check("ptr_no_req", reg_we | reg_re | stall, 0);
    end else if (mode == M_WDATA) begin
      service(1'b1, delay, b);
    end else begin
      check("rx_ignored", reg_we | reg_re | stall, 0);
    end
  endtask

  task automatic tx_byte(input int delay);
    step();
    tx_done = 1'b1;
    #1;
    check("txdone_stall", stall, mode == M_RD);
    step();
    tx_done = 1'b0;
    #1;
    if (mode == M_RD) service(1'b0, delay, 8'h00);
    else check("txdone_ignored", reg_we | reg_re | stall, 0);
  endtask

  initial begin
    logic [6:0] miss;
    rst = 1'b1; addr_stb = 0; rx_stb = 0; tx_done = 0; err_stb = 0; reg_ack = 0;
    i2c_addr_rw = 0; i2c_data_rx = 0; reg_rdata = 0;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_regs[i]  = slave_mem[i];
    end
    ref_ptr = 0; mode = M_IDLE; exp_to = 1'b0;
    repeat (3) step();
    check("rst_stall", stall, 0);
    check("rst_we_re", {reg_we, reg_re}, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_tx", i2c_data_tx, 0);
    check("rst_timeout", timeout_err, 0);
    rst = 1'b0;

    // write 0x03 pointer then 0xAA, 0xBB with ack two cycles into each access
    addr_phase(DEV, 1'b0, 0);
    rx_byte(8'h03, 0);
    rx_byte(8'hAA, 2);
    rx_byte(8'hBB, 2);
    check("dir_reg3", slave_mem[3], 8'hAA);
    check("dir_reg4", slave_mem[4], 8'hBB);

    // read across the pointer wrap
    slave_mem[14] = 8'h11; slave_mem[15] = 8'h22; slave_mem[0] = 8'h33;
    ref_regs[14]  = 8'h11; ref_regs[15]  = 8'h22; ref_regs[0]  = 8'h33;
    addr_phase(DEV, 1'b0, 0);
    rx_byte(8'h0E, 0);
    addr_phase(DEV, 1'b1, 1);
    tx_byte(1);
    tx_byte(0);
    check("wrap_tx", i2c_data_tx, 8'h33);
    tx_byte(3);

    // foreign address: data must not reach the register bus
    addr_phase(7'h50, 1'b0, 0);
    rx_byte(8'h01, 0);
    rx_byte(8'h99, 0);
    tx_byte(0);

    // withheld ack on a read, then a retry of the same register
    addr_phase(DEV, 1'b1, 1000);
    tx_byte(0);

    // bus error coinciding with ack during a write
    addr_phase(DEV, 1'b0, 0);
    rx_byte(8'h05, 0);
    step();
    i2c_data_rx = 8'h77; rx_stb = 1'b1;
    #1;
    check("err_launch_stall", stall, 1);
    step();
    rx_stb = 1'b0;
    #1;
    check("err_pre_we", reg_we, 1);
    step();
    err_stb = 1'b1; reg_ack = 1'b1;
    slave_mem[reg_addr] = reg_wdata;
    ref_regs[5] = 8'h77;
    step();
    err_stb = 1'b0; reg_ack = 1'b0;
    #1;
    check("err_drop", {reg_we, reg_re, stall}, 0);
    mode = M_IDLE;
    addr_phase(DEV, 1'b1, 1);

    // reset in the middle of a read, then a stray ack
    step();
    i2c_addr_rw = {DEV, 1'b1}; addr_stb = 1'b1;
    step();
    addr_stb = 1'b0;
    #1;
    check("rst_pre_re", reg_re, 1);
    rst = 1'b1;
    step();
    check("rst_drop", {reg_we, reg_re, stall}, 0);
    check("rst_clr_to", timeout_err, 0);
    rst = 1'b0; reg_ack = 1'b1; reg_rdata = 8'h5A;
    step();
    reg_ack = 1'b0;
    #1;
    check("late_ack_tx", i2c_data_tx, 0);
    check("late_ack_re", reg_re, 0);
    ref_ptr = 0; exp_to = 1'b0; mode = M_IDLE;
    addr_phase(DEV, 1'b1, 0);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          addr_phase(DEV, 1'b0, 0);
          rx_byte(8'($urandom), 0);
          repeat ($urandom_range(1, 3)) rx_byte(8'($urandom), $urandom_range(0, 4));
        end
        1: begin
          addr_phase(DEV, 1'b1, $urandom_range(0, 4));
          repeat ($urandom_range(1, 3)) tx_byte($urandom_range(0, 4));
        end
        2: begin
          miss = DEV ^ (7'd1 << $urandom_range(0, 6));
          addr_phase(miss, 1'($urandom), 0);
          rx_byte(8'($urandom), 0);
          tx_byte(0);
        end
        3: begin
          rx_byte(8'($urandom), $urandom_range(0, 4));
          tx_byte($urandom_range(0, 4));
        end
        default: begin
          if (mode == M_WDATA) rx_byte(8'($urandom), 1000);
          else tx_byte(1000);
        end
      endcase
    end

    for (int i = 0; i < 16; i++) check("final_regs", slave_mem[i], ref_regs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
